// File: rtl/data_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_if
// Purpose  : Request/acknowledge bus between the CPU memory port (master)
//            and the data memory responder (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface data_mem_if;
    logic        req;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        err;
    logic        busy;

    modport master (
        output req, wr, addr, wdata,
        input  rdata, ack, err, busy
    );

    modport slave (
        input  req, wr, addr, wdata,
        output rdata, ack, err, busy
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Word-addressed 32-bit RAM behind a request/acknowledge slave
//            port. Inserts WAIT_CYCLES wait states after acceptance and
//            rejects misaligned or out-of-range accesses with err.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic      Clk,
    input  logic      Reset,
    data_mem_if.slave bus
);

    localparam int          c_IDX_W   = $clog2(DEPTH);
    localparam logic [3:0]  c_WAIT    = 4'(WAIT_CYCLES);
    localparam logic [29:0] c_DEPTH_W = 30'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_latWr;
    logic [31:0]         r_latAddr;
    logic [31:0]         r_latWdata;
    logic [31:0]         r_rdata;
    logic                r_ack;
    logic                r_err;
    logic                r_busy;
    logic [31:0]         r_mem [DEPTH];

    logic                w_legal;
    logic                w_access;
    logic [c_IDX_W-1:0]  w_idx;

    // The whole word index is compared against DEPTH so that high address
    // bits cannot alias back into the array.
    assign w_legal  = (r_latAddr[1:0] == 2'b00) && (r_latAddr[31:2] < c_DEPTH_W);
    assign w_idx    = r_latAddr[c_IDX_W+1:2];
    assign w_access = (r_state == BUSY) && (r_cnt == 4'd0);

    assign bus.rdata = r_rdata;
    assign bus.ack   = r_ack;
    assign bus.err   = r_err;
    assign bus.busy  = r_busy;

    // Control FSM: accept and latch a request, count wait states, respond.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_latWr    <= 1'b0;
            r_latAddr  <= 32'd0;
            r_latWdata <= 32'd0;
            r_rdata    <= 32'd0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req) begin
                        r_latWr    <= bus.wr;
                        r_latAddr  <= bus.addr;
                        r_latWdata <= bus.wdata;
                        r_cnt      <= c_WAIT;
                        r_busy     <= 1'b1;
                        r_state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_ack   <= 1'b1;
                        r_state <= RESP;
                        if (!w_legal) begin
                            r_err   <= 1'b1;
                            r_rdata <= 32'd0;
                        end else begin
                            r_err <= 1'b0;
                            // A legal write leaves rdata untouched.
                            if (!r_latWr) begin
                                r_rdata <= r_mem[w_idx];
                            end
                        end
                    end
                end
                RESP: begin
                    // req is deliberately not sampled here; a held req is
                    // picked up as a fresh request in the following IDLE.
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Storage array: cleared on reset, written only by a legal latched write.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else if (w_access && w_legal && r_latWr) begin
            r_mem[w_idx] <= r_latWdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Purpose  : Self-checking bench for data_mem_responder with WAIT_CYCLES=2
//            and WAIT_CYCLES=0 instances against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int DEPTH = 64;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    always #5 Clk = ~Clk;

    data_mem_if bus0();
    data_mem_if bus1();

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut0 (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus0)
    );

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut1 (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus1)
    );

    // Shared initiator; sel picks which instance sees req.
    logic        req;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        sel;

    assign bus0.req   = req & ~sel;
    assign bus0.wr    = wr;
    assign bus0.addr  = addr;
    assign bus0.wdata = wdata;
    assign bus1.req   = req & sel;
    assign bus1.wr    = wr;
    assign bus1.addr  = addr;
    assign bus1.wdata = wdata;

    logic        oAck;
    logic        oErr;
    logic        oBusy;
    logic [31:0] oRdata;
    assign oAck   = sel ? bus1.ack   : bus0.ack;
    assign oErr   = sel ? bus1.err   : bus0.err;
    assign oBusy  = sel ? bus1.busy  : bus0.busy;
    assign oRdata = sel ? bus1.rdata : bus0.rdata;

    int errors = 0;
    int checks = 0;

    // Reference model: array contents and the rdata register of each instance.
    logic [31:0] model [2][DEPTH];
    logic [31:0] expRd [2];

    function automatic void clear_models();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < DEPTH; i++) model[s][i] = 32'd0;
            expRd[s] = 32'd0;
        end
    endfunction

    function automatic int wait_of(input logic s);
        return s ? 0 : 2;
    endfunction

    // One complete transaction; caller is aligned to a falling edge.
    task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic scramble, input string tag);
        int n = 0;
        int busyCnt = 0;
        int s = sel ? 1 : 0;
        int lat = wait_of(sel);
        logic eErr;
        req = 1'b1; wr = w; addr = a; wdata = d;
        if (a[1:0] != 2'b00 || a[31:2] >= 30'(DEPTH)) begin
            eErr = 1'b1;
            expRd[s] = 32'd0;
        end else begin
            eErr = 1'b0;
            if (w) model[s][int'(a[31:2])] = d;
            else   expRd[s] = model[s][int'(a[31:2])];
        end
        do begin
            @(negedge Clk);
            n++;
            if (oBusy) busyCnt++;
            if (scramble && n == 1) begin
                addr = $urandom; wdata = $urandom; wr = ~w;
            end
        end while (!oAck && n < 40);
        req = 1'b0;
        checks++;
        if (oAck !== 1'b1) begin
            errors++; $display("FAIL %s ack_timeout: got %b expected 1", tag, oAck);
        end
        checks++;
        if (n != lat + 2) begin
            errors++; $display("FAIL %s latency: got %0d expected %0d", tag, n, lat + 2);
        end
        checks++;
        if (oErr !== eErr) begin
            errors++; $display("FAIL %s err: got %b expected %b", tag, oErr, eErr);
        end
        checks++;
        if (oRdata !== expRd[s]) begin
            errors++; $display("FAIL %s rdata: got %h expected %h", tag, oRdata, expRd[s]);
        end
        checks++;
        if (busyCnt != lat + 2) begin
            errors++; $display("FAIL %s busy_cycles: got %0d expected %0d", tag, busyCnt, lat + 2);
        end
        @(negedge Clk);
        checks++;
        if (oAck !== 1'b0 || oErr !== 1'b0 || oBusy !== 1'b0) begin
            errors++;
            $display("FAIL %s after_resp: got ack=%b err=%b busy=%b expected 0 0 0",
                     tag, oAck, oErr, oBusy);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        checks++;
        if (bus0.ack !== 1'b0 || bus0.err !== 1'b0 || bus0.busy !== 1'b0 || bus0.rdata !== 32'd0 ||
            bus1.ack !== 1'b0 || bus1.err !== 1'b0 || bus1.busy !== 1'b0 || bus1.rdata !== 32'd0) begin
            errors++;
            $display("FAIL %s: got ack=%b/%b err=%b/%b busy=%b/%b rdata=%h/%h expected all 0",
                     tag, bus0.ack, bus1.ack, bus0.err, bus1.err, bus0.busy, bus1.busy,
                     bus0.rdata, bus1.rdata);
        end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        check_idle_zero("reset_outputs");
        Reset = 1'b1;
        clear_models();
        @(negedge Clk);
        // Dirty the array, then pulse reset and read back.
        do_txn(1'b1, 32'h0, 32'hFFFF_FFFF, 1'b0, "dirty_wr");
        do_txn(1'b0, 32'h0, 32'h0, 1'b0, "dirty_rd");
        Reset = 1'b0;
        @(negedge Clk);
        check_idle_zero("reset_pulse_outputs");
        Reset = 1'b1;
        clear_models();
        @(negedge Clk);
        do_txn(1'b0, 32'h0, 32'h0, 1'b0, "rd0_after_reset");
    endtask

    task automatic test_write_read();
        sel = 1'b0;
        do_txn(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, "wr_10");
        do_txn(1'b0, 32'h10, 32'h0, 1'b0, "rd_10");
    endtask

    task automatic test_illegal();
        sel = 1'b0;
        do_txn(1'b1, 32'h00, 32'h1357_9BDF, 1'b0, "wr_00");
        do_txn(1'b0, 32'h00, 32'h0, 1'b0, "rd_00");
        do_txn(1'b0, 32'h12, 32'h0, 1'b0, "rd_misaligned");
        do_txn(1'b0, 32'h00, 32'h0, 1'b0, "rd_00_b");
        do_txn(1'b1, 32'h100, 32'hFFFF_0000, 1'b0, "wr_out_of_range");
        do_txn(1'b0, 32'h00, 32'h0, 1'b0, "rd_00_no_corrupt");
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int m = 0;
        sel = 1'b0;
        req = 1'b1; wr = 1'b1; addr = 32'h04; wdata = 32'h1;
        model[0][1] = 32'h1;
        do begin @(negedge Clk); n++; end while (!oAck && n < 40);
        checks++;
        if (oAck !== 1'b1 || oErr !== 1'b0) begin
            errors++; $display("FAIL b2b_first_ack: got ack=%b err=%b expected 1 0", oAck, oErr);
        end
        // Keep req high; switch to a read of the same word.
        wr = 1'b0;
        do begin @(negedge Clk); m++; end while (!oAck && m < 40);
        req = 1'b0;
        expRd[0] = 32'h1;
        checks++;
        if (m != wait_of(1'b0) + 3) begin
            errors++; $display("FAIL b2b_spacing: got %0d expected %0d", m, wait_of(1'b0) + 3);
        end
        checks++;
        if (oRdata !== 32'h1 || oErr !== 1'b0) begin
            errors++; $display("FAIL b2b_read: got rdata=%h err=%b expected 00000001 0", oRdata, oErr);
        end
        @(negedge Clk);
    endtask

    task automatic test_latched_inputs();
        sel = 1'b0;
        do_txn(1'b1, 32'h08, 32'hAAAA_5555, 1'b1, "wr_08_scrambled");
        do_txn(1'b0, 32'h08, 32'h0, 1'b0, "rd_08");
    endtask

    task automatic test_reset_mid(input logic s, input string tag);
        sel = s;
        do_txn(1'b1, 32'h0C, 32'hCAFE_F00D, 1'b0, "pre_dirty_0C");
        req = 1'b1; wr = 1'b1; addr = 32'h0C; wdata = 32'h1234_5678;
        @(negedge Clk);
        checks++;
        if (oBusy !== 1'b1) begin
            errors++; $display("FAIL %s busy_before_abort: got %b expected 1", tag, oBusy);
        end
        Reset = 1'b0;
        #1;
        check_idle_zero(tag);
        req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            checks++;
            if (oAck !== 1'b0) begin
                errors++; $display("FAIL %s ack_during_reset: got %b expected 0", tag, oAck);
            end
        end
        Reset = 1'b1;
        clear_models();
        @(negedge Clk);
        do_txn(1'b0, 32'h0C, 32'h0, 1'b0, "rd_0C_after_abort");
    endtask

    task automatic test_random();
        logic [31:0] a;
        int idx;
        int kind;
        for (int t = 0; t < 60; t++) begin
            sel  = $urandom_range(0, 1) == 1;
            kind = $urandom_range(0, 9);
            idx  = $urandom_range(0, 15);
            if (kind == 0)      a = (32'(idx) << 2) | 32'($urandom_range(1, 3));
            else if (kind == 1) a = 32'($urandom_range(DEPTH, DEPTH + 7)) << 2;
            else if (kind == 2) a = 32'h8000_0000 | (32'(idx) << 2);
            else if (kind == 3) a = 32'($urandom_range(0, DEPTH - 1)) << 2;
            else                a = 32'(idx) << 2;
            do_txn($urandom_range(0, 1) == 1, a, $urandom, $urandom_range(0, 3) == 0, "random");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        req = 1'b0; wr = 1'b0; addr = 32'd0; wdata = 32'd0; sel = 1'b0;
        clear_models();
        @(negedge Clk);
        test_reset();
        test_write_read();
        test_illegal();
        test_back_to_back();
        test_latched_inputs();
        test_reset_mid(1'b0, "abort_wait2");
        test_reset_mid(1'b1, "abort_wait0");
        sel = 1'b1;
        do_txn(1'b1, 32'h14, 32'h0BAD_CAFE, 1'b0, "w0_wr");
        do_txn(1'b0, 32'h14, 32'h0, 1'b0, "w0_rd");
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the multicycle CPU's data/instruction port; replaces the zero-latency memory model with a request/acknowledge slave.
- Holds a word-addressed 32-bit RAM array, adds a configurable number of wait states and flags illegal accesses.
- Sits between the CPU datapath and storage; the control unit waits on `ack` before advancing.

Parameters:
- DEPTH, 64, number of 32-bit words in the array (power of two, 4..1024).
- WAIT_CYCLES, 2, wait states inserted between acceptance and access (0..15).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- req  in  1  initiator request; held high with wr/addr/wdata stable until ack.
- wr  in  1  1 = write, 0 = read.
- addr  in  32  byte address; must be word aligned.
- wdata  in  32  write data.
- rdata  out  32  read data, valid in the ack cycle of a successful read.
- ack  out  1  one-cycle response pulse.
- err  out  1  valid with ack; 1 = access rejected.
- busy  out  1  high from acceptance until the cycle after ack.

Behaviour:
- Reset (Reset=0, asynchronous):
  - state=IDLE; ack=0, err=0, rdata=0, busy=0.
  - Wait counter=0; latched request cleared; all DEPTH words cleared to 0.
- Reset asserted mid-transaction aborts it: no array write, no ack.
- All outputs are registered.
- State machine, three states: IDLE, BUSY, RESP.
- IDLE:
  - req=1 at a rising edge: latch wr, addr, wdata; cnt<=WAIT_CYCLES; busy<=1; go BUSY.
  - req=0: stay in IDLE.
- BUSY, cnt!=0: cnt<=cnt-1, stay in BUSY.
- BUSY, cnt==0: perform the access on the latched request, ack<=1, go RESP.
  - Illegal access: latched addr[1:0]!=0 or latched addr[31:2]>=DEPTH.
    - err<=1; no array write; rdata<=0.
  - Legal read: rdata<=mem[addr[31:2]]; err<=0.
  - Legal write: mem[addr[31:2]]<=wdata; err<=0; rdata holds its previous value.
- RESP:
  - ack<=0, err<=0, busy<=0; go IDLE.
  - req is ignored in this cycle.
- Latency:
  - Accepted at edge E0 → ack high during the cycle following edge E0+WAIT_CYCLES+1.
  - Minimum request-to-request spacing is WAIT_CYCLES+3 cycles.
- Back-to-back: if req is still high in IDLE after RESP, it is a new transaction. The initiator must drop req in the ack cycle to avoid a repeat.
- Input changes while in BUSY are ignored; the latched copy is used.
- Only addr[31:2] and addr[1:0] are decoded; upper bits beyond the DEPTH range trigger err.
- WAIT_CYCLES=0: BUSY lasts exactly one cycle.
- A read following a write to the same word returns the new data; there is no bypass hazard, since accesses are serialized.
- The array is readable and writable only through this port; there is no preload port.

Test Plan:
- Reset pulse with array dirty, then read addr 0x00 → ack after 3 wait edges, rdata=0, err=0, busy observed high for WAIT_CYCLES+2 cycles.
- Write 0xDEADBEEF to 0x10, then read 0x10 → write ack with err=0; read ack with rdata=0xDEADBEEF.
- Read 0x12 (misaligned), then write 0x100 with DEPTH=64 (out of range) → both ack with err=1, rdata=0. A follow-up read of 0x00 shows no corruption.
- req held high across ack: write 0x04 ← 0x1, then keep req for a read of 0x04 → second transaction starts in the IDLE cycle after RESP. The second ack arrives exactly WAIT_CYCLES+3 cycles after the first, with rdata=0x1.
- Change addr/wdata during BUSY on a write to 0x08 ← 0xAAAA5555 → the original latched values are written; a read of 0x08 returns 0xAAAA5555.
- Assert Reset during BUSY of a write 0x0C ← 0x12345678 → ack never pulses, outputs return to 0 immediately, and a read of 0x0C returns 0. Repeat with WAIT_CYCLES=0 to check one-cycle BUSY timing.
